// File: rtl/io_pkg.sv
// Shared defaults for the processor-side I/O bridge.
package io_pkg;
   localparam int IO_DATA_W    = 16;
   localparam int IO_OUT_DEPTH = 4;
   localparam int PTR_W        = $clog2(IO_OUT_DEPTH);
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty and a zero-when-empty head word.
module sync_fifo
   import io_pkg::*;
#(
   parameter  int DATA_W = IO_DATA_W,
   parameter  int DEPTH  = IO_OUT_DEPTH,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [AW:0]       count_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_q, wr_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic [AW:0]       count_q, count_d;
   logic              push_ok, pop_ok;

   // Full/empty come from the registered count only, so a pop never frees
   // a slot for a push in the same cycle.
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = empty_o ? '0 : mem[rd_q];

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_q] <= din_i;
   end

endmodule

// File: rtl/io_port_ctrl.sv
// Core-side IN/OUT bridge: transmit FIFO toward the peripheral, one-word receive holding register.
module io_port_ctrl
   import io_pkg::*;
#(
   parameter int DATA_W    = IO_DATA_W,
   parameter int OUT_DEPTH = IO_OUT_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              out_req,
   input  logic [DATA_W-1:0] out_data,
   input  logic              in_req,
   output logic [DATA_W-1:0] in_data,
   output logic              in_ack,
   output logic              stall,
   output logic              out_empty,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready
);

   localparam int AW = $clog2(OUT_DEPTH);

   logic              tx_full, tx_empty;
   logic [AW:0]       tx_count;
   logic              rx_full_q, rx_full_d;
   logic [DATA_W-1:0] rx_buf_q, rx_buf_d;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (OUT_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (out_req),
      .din_i   (out_data),
      .pop_i   (tx_ready),
      .dout_o  (tx_data),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count)
   );

   assign tx_valid  = !tx_empty;
   assign out_empty = tx_empty;

   assign rx_ready = !rx_full_q;
   assign in_data  = rx_buf_q;
   assign in_ack   = in_req && rx_full_q;
   assign stall    = (out_req && tx_full) || (in_req && !rx_full_q);

   // Ack and capture are mutually exclusive (ack needs full, capture needs empty),
   // so the register refills no sooner than the cycle after a read.
   always_comb begin
      rx_full_d = rx_full_q;
      rx_buf_d  = rx_buf_q;
      if (in_ack) begin
         rx_full_d = 1'b0;
      end else if (rx_valid && rx_ready) begin
         rx_full_d = 1'b1;
         rx_buf_d  = rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_full_q <= 1'b0;
         rx_buf_q  <= '0;
      end else begin
         rx_full_q <= rx_full_d;
         rx_buf_q  <= rx_buf_d;
      end
   end

   logic unused_count;
   assign unused_count = ^tx_count;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with hand-computed expectations.
module tb_io_port_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        out_req;
   logic [15:0] out_data;
   logic        in_req;
   logic [15:0] in_data;
   logic        in_ack;
   logic        stall;
   logic        out_empty;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;

   int total = 0;
   int bad   = 0;

   io_port_ctrl #(.DATA_W(16), .OUT_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .out_req   (out_req),
      .out_data  (out_data),
      .in_req    (in_req),
      .in_data   (in_data),
      .in_ack    (in_ack),
      .stall     (stall),
      .out_empty (out_empty),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed and outputs checked mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; out_req = 0; out_data = 0; in_req = 0; tx_ready = 0;
      rx_data = 0; rx_valid = 0;
      #2;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_out_empty", out_empty, 1);
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_in_ack", in_ack, 0);
      chk("rst_stall", stall, 0);
      chk("rst_in_data", in_data, 0);
      tick(); tick();
      rst = 1'b0;
      #1;

      // Fill the FIFO with tx_ready low
      for (int i = 1; i <= 4; i++) begin
         out_req = 1; out_data = 16'(i);
         #1 chk("fill_stall", stall, 0);
         tick();
         chk("fill_head", tx_data, 1);
      end
      chk("fill_count", dut.u_fifo.count_o, 4);
      out_data = 16'h0005;
      #1 chk("full_stall", stall, 1);
      tick();
      chk("full_stall_hold", stall, 1);
      chk("full_count_hold", dut.u_fifo.count_o, 4);
      tx_ready = 1;
      #1 chk("drain_head1", tx_data, 16'h0001);
      chk("drain_stall1", stall, 1);
      tick();
      chk("drain_head2", tx_data, 16'h0002);
      chk("drain_stall2", stall, 0);
      tick();
      out_req = 0;
      #1 chk("drain_head3", tx_data, 16'h0003);
      tick(); chk("drain_head4", tx_data, 16'h0004);
      tick(); chk("drain_head5", tx_data, 16'h0005);
      tick(); chk("drain_empty", out_empty, 1);
      chk("drain_valid", tx_valid, 0);

      // Full FIFO with simultaneous pop and refused push
      tx_ready = 0;
      for (int i = 0; i < 4; i++) begin
         out_req = 1; out_data = 16'h0011 + 16'(i);
         tick();
      end
      out_data = 16'h00AA; tx_ready = 1;
      #1 chk("sim_stall", stall, 1);
      chk("sim_head", tx_data, 16'h0011);
      tick();
      chk("sim_stall_next", stall, 0);
      chk("sim_head2", tx_data, 16'h0012);
      tick();
      out_req = 0;
      #1 chk("sim_head3", tx_data, 16'h0013);
      tick(); chk("sim_head4", tx_data, 16'h0014);
      tick(); chk("sim_head_aa", tx_data, 16'h00AA);
      tick(); chk("sim_empty", out_empty, 1);

      // Streaming one word per cycle through the FIFO
      for (int k = 0; k <= 16; k++) begin
         out_req  = (k < 16);
         out_data = 16'h1000 + 16'(k);
         #1 chk("stream_stall", stall, 0);
         if (k >= 1) begin
            chk("stream_valid", tx_valid, 1);
            chk("stream_data", tx_data, 32'h1000 + 32'(k - 1));
            chk("stream_count", dut.u_fifo.count_o, 1);
         end
         tick();
      end
      chk("stream_empty", out_empty, 1);
      tx_ready = 0;

      // IN read that waits for a word
      in_req = 1;
      #1 chk("in_wait_stall", stall, 1);
      chk("in_wait_ack", in_ack, 0);
      tick();
      rx_valid = 1; rx_data = 16'hBEEF;
      #1 chk("in_rx_ready", rx_ready, 1);
      chk("in_stall_still", stall, 1);
      tick();
      rx_valid = 0;
      #1 chk("in_ack", in_ack, 1);
      chk("in_data", in_data, 16'hBEEF);
      chk("in_stall_clear", stall, 0);
      chk("in_rx_busy", rx_ready, 0);
      tick();
      in_req = 0;
      #1 chk("in_rx_ready_back", rx_ready, 1);
      chk("in_ack_done", in_ack, 0);

      // Held rx_valid while the holding register is occupied
      rx_valid = 1; rx_data = 16'h5555;
      tick();
      rx_data = 16'h1234;
      #1 chk("hold_rx_ready", rx_ready, 0);
      chk("hold_buf", in_data, 16'h5555);
      tick();
      chk("hold_buf2", in_data, 16'h5555);
      in_req = 1;
      #1 chk("hold_ack", in_ack, 1);
      tick();
      in_req = 0;
      #1 chk("hold_ready_after_ack", rx_ready, 1);
      chk("hold_buf3", in_data, 16'h5555);
      tick();
      rx_valid = 0;
      #1 chk("hold_capture", in_data, 16'h1234);
      chk("hold_full", rx_ready, 0);

      // Asynchronous reset with queued words and a buffered rx word
      for (int i = 0; i < 3; i++) begin
         out_req = 1; out_data = 16'h0700 + 16'(i);
         tick();
      end
      out_req = 0;
      #1 chk("pre_rst_valid", tx_valid, 1);
      chk("pre_rst_count", dut.u_fifo.count_o, 3);
      #2 rst = 1;
      #1 chk("arst_tx_valid", tx_valid, 0);
      chk("arst_out_empty", out_empty, 1);
      chk("arst_rx_ready", rx_ready, 1);
      chk("arst_in_data", in_data, 0);
      chk("arst_tx_data", tx_data, 0);
      #1 rst = 0;
      tick();
      chk("post_rst_empty", out_empty, 1);
      chk("post_rst_valid", tx_valid, 0);
      out_req = 1; out_data = 16'h4242;
      tick();
      out_req = 0;
      #1 chk("post_rst_head", tx_data, 16'h4242);
      chk("post_rst_count", dut.u_fifo.count_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
